halt_monitor: RTL and testbench

HALT_MONITOR -- requirements
Module: halt_monitor

---
 rtl/halt_monitor_pkg.sv | 23 ++
 rtl/pc_trace_ring.sv | 38 +++
 rtl/halt_monitor.sv | 131 +++++++++++++
 tb/tb_halt_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/halt_monitor_pkg.sv
// Shared types and constants for the simulation halt monitor.
package halt_monitor_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_EBREAK  = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_STALL   = 2'b11
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/pc_trace_ring.sv
// Eight-entry ring of recent commit PCs; read index 0 is the most recent write.
module pc_trace_ring
    import halt_monitor_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_pc
);

    logic [31:0] ring_r [8];
    logic [2:0]  wr_ptr_r;
    logic [2:0]  rd_slot_s;

    // Ring storage and write pointer; reset zeroes every slot so unwritten entries read 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                ring_r[i] <= 32'd0;
            end
            wr_ptr_r <= 3'd0;
        end else if (wr_en) begin
            ring_r[wr_ptr_r] <= wr_pc;
            wr_ptr_r         <= wr_ptr_r + 3'd1;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Combinational lookback from the newest slot.
    always_comb begin
        rd_slot_s = wr_ptr_r - 3'd1 - rd_idx;
        rd_pc     = ring_r[rd_slot_s];
    end

endmodule

// File: rtl/halt_monitor.sv
// Simulation halt monitor: ebreak / timeout / stall detection with retired-instruction stats.
// Optional PC trace ring enabled by defining HALT_MONITOR_TRACE_EN.
module halt_monitor
    import halt_monitor_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
    parameter logic [15:0] STALL_LIMIT    = 16'd1024,
    parameter logic [3:0]  DRAIN_CYCLES   = 4'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic [31:0] a0,
    output logic        halted,
    output logic        good_trap,
    output logic [1:0]  halt_cause,
    output logic [63:0] cycle_cnt,
    output logic [63:0] inst_cnt,
    output logic [31:0] halt_pc
`ifdef HALT_MONITOR_TRACE_EN
    ,
    input  logic [2:0]  trace_idx,
    output logic [31:0] trace_pc
`endif
);

    state_e      state_r, state_s;
    halt_cause_e cause_r, cause_s;
    logic [63:0] cycle_cnt_r, inst_cnt_r, cycle_next_s;
    logic [31:0] halt_pc_r, a0_r;
    logic [15:0] stall_r, stall_next_s;
    logic [3:0]  drain_r;
    logic        halted_r, good_trap_r;
    logic        ebreak_s, timeout_s, stall_hit_s, drain_done_s;

    // Next-state and halt-cause selection; ebreak outranks timeout, which outranks stall.
    always_comb begin
        state_s      = state_r;
        cause_s      = cause_r;
        cycle_next_s = cycle_cnt_r + 64'd1;
        stall_next_s = commit_valid ? 16'd0 : (stall_r + 16'd1);
        ebreak_s     = commit_valid && is_ebreak(commit_inst);
        timeout_s    = (cycle_next_s == {32'd0, TIMEOUT_CYCLES - 32'd1});
        stall_hit_s  = !commit_valid && (stall_next_s == STALL_LIMIT);
        drain_done_s = (({1'b0, drain_r} + 5'd1) >= {1'b0, DRAIN_CYCLES});
        case (state_r)
            ST_RUN: begin
                if (ebreak_s) begin
                    state_s = ST_DRAIN;
                    cause_s = CAUSE_EBREAK;
                end else if (timeout_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_TIMEOUT;
                end else if (stall_hit_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_STALL;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_RUN;
        endcase
    end

    // FSM state, counters and latched halt information.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            cause_r     <= CAUSE_NONE;
            cycle_cnt_r <= 64'd0;
            inst_cnt_r  <= 64'd0;
            halt_pc_r   <= 32'd0;
            a0_r        <= 32'd0;
            stall_r     <= 16'd0;
            drain_r     <= 4'd0;
            halted_r    <= 1'b0;
            good_trap_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cause_r     <= cause_s;
            // Status flags follow the HALT state by one cycle, giving the DRAIN_CYCLES+1 ebreak latency.
            halted_r    <= (state_r == ST_HALT);
            good_trap_r <= (state_r == ST_HALT) && (cause_r == CAUSE_EBREAK) && (a0_r == 32'd0);
            case (state_r)
                ST_RUN: begin
                    cycle_cnt_r <= cycle_next_s;
                    stall_r     <= stall_next_s;
                    drain_r     <= 4'd0;
                    if (commit_valid) begin
                        inst_cnt_r <= inst_cnt_r + 64'd1;
                        halt_pc_r  <= commit_pc;
                    end
                    if (ebreak_s) begin
                        a0_r <= a0;
                    end
                end
                ST_DRAIN: drain_r <= drain_r + 4'd1;
                default:  drain_r <= drain_r;
            endcase
        end
    end

    assign halted     = halted_r;
    assign good_trap  = good_trap_r;
    assign halt_cause = cause_r;
    assign cycle_cnt  = cycle_cnt_r;
    assign inst_cnt   = inst_cnt_r;
    assign halt_pc    = halt_pc_r;

`ifdef HALT_MONITOR_TRACE_EN
    pc_trace_ring u_trace (
        .clock  (clock),
        .reset  (reset),
        .wr_en  ((state_r == ST_RUN) && commit_valid),
        .wr_pc  (commit_pc),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc)
    );
`endif

endmodule

// File: tb/tb_halt_monitor.sv
// Self-checking bench for halt_monitor: directed scenarios plus randomized episodes
// compared against an event-timing reference model.
module tb_halt_monitor;

    localparam int          TIMEOUT = 100;
    localparam int          STALL   = 8;
    localparam int          DRAIN   = 2;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] ADDI    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst, a0;
    logic        halted, good_trap;
    logic [1:0]  halt_cause;
    logic [63:0] cycle_cnt, inst_cnt;
    logic [31:0] halt_pc;
`ifdef HALT_MONITOR_TRACE_EN
    logic [2:0]  trace_idx;
    logic [31:0] trace_pc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: counters plus the edge index at which halted is due
    int          m_t, m_halt_at, m_stall;
    bit          m_stopped;
    longint      m_cyc, m_inst;
    logic [31:0] m_pc, m_a0;
    logic [1:0]  m_cause;
    logic [31:0] m_trace[$];

    halt_monitor #(
        .TIMEOUT_CYCLES(32'd100),
        .STALL_LIMIT   (16'd8),
        .DRAIN_CYCLES  (4'd2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .a0          (a0),
        .halted      (halted),
        .good_trap   (good_trap),
        .halt_cause  (halt_cause),
        .cycle_cnt   (cycle_cnt),
        .inst_cnt    (inst_cnt),
        .halt_pc     (halt_pc)
`ifdef HALT_MONITOR_TRACE_EN
        ,
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_halt_at = 1000000; m_stall = 0; m_stopped = 1'b0;
        m_cyc = 0; m_inst = 0; m_pc = 32'd0; m_a0 = 32'd0; m_cause = 2'b00;
        m_trace.delete();
    endtask

    task automatic model_step(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] a0v);
        m_t++;
        if (!m_stopped) begin
            m_cyc++;
            if (cv) begin
                m_inst++;
                m_pc = pc;
                m_stall = 0;
                m_trace.push_back(pc);
                if (m_trace.size() > 8) void'(m_trace.pop_front());
            end else begin
                m_stall++;
            end
            if (cv && inst == EBREAK) begin
                m_stopped = 1'b1; m_cause = 2'b01; m_a0 = a0v; m_halt_at = m_t + DRAIN + 1;
            end else if (m_cyc == TIMEOUT - 1) begin
                m_stopped = 1'b1; m_cause = 2'b10; m_halt_at = m_t + 1;
            end else if (!cv && m_stall == STALL) begin
                m_stopped = 1'b1; m_cause = 2'b11; m_halt_at = m_t + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic h;
        h = (m_t >= m_halt_at);
        check({tag, ".halted"},     {63'd0, halted},    {63'd0, h});
        check({tag, ".good_trap"},  {63'd0, good_trap}, {63'd0, h && m_cause == 2'b01 && m_a0 == 32'd0});
        check({tag, ".halt_cause"}, {62'd0, halt_cause}, {62'd0, m_cause});
        check({tag, ".cycle_cnt"},  cycle_cnt, m_cyc);
        check({tag, ".inst_cnt"},   inst_cnt,  m_inst);
        check({tag, ".halt_pc"},    {32'd0, halt_pc}, {32'd0, m_pc});
`ifdef HALT_MONITOR_TRACE_EN
        begin
            int idx;
            logic [31:0] exp_pc;
            idx = $urandom_range(0, 7);
            trace_idx = idx[2:0];
            #1;
            exp_pc = (idx < m_trace.size()) ? m_trace[m_trace.size() - 1 - idx] : 32'd0;
            check({tag, ".trace_pc"}, {32'd0, trace_pc}, {32'd0, exp_pc});
        end
`endif
    endtask

    // one clock: apply inputs, let the edge happen, step the model, compare on the falling edge
    task automatic tick(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] a0v, input string tag);
        commit_valid = cv; commit_pc = pc; commit_inst = inst; a0 = a0v;
        @(posedge clock);
        model_step(cv, pc, inst, a0v);
        @(negedge clock);
        check_all(tag);
    endtask

    // reset asserted at a falling edge: outputs must clear without waiting for a clock
    task automatic reset_pulse();
        commit_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_random(input int p_valid, input int p_ebreak, input int n);
        logic        cv;
        logic [31:0] inst, a0v;
        reset_pulse();
        for (int i = 0; i < n; i++) begin
            cv   = ($urandom_range(0, 99) < p_valid);
            inst = ($urandom_range(0, 99) < p_ebreak) ? EBREAK :
                   (($urandom_range(0, 1) == 0) ? ADDI : ($urandom() | 32'h0000_0003));
            a0v  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom();
            tick(cv, $urandom() & 32'hFFFF_FFFC, inst, a0v, "rand");
        end
    endtask

    initial begin
        commit_valid = 1'b0; commit_pc = 32'd0; commit_inst = 32'd0; a0 = 32'd0;
        reset = 1'b1;
`ifdef HALT_MONITOR_TRACE_EN
        trace_idx = 3'd0;
`endif
        @(negedge clock);
        @(negedge clock);
        reset_pulse();

        // 10 addi commits then ebreak with a0==0
        for (int i = 0; i < 10; i++) tick(1'b1, 32'h8000_0000 + 32'(4 * i), ADDI, 32'd5, "addi");
`ifdef HALT_MONITOR_TRACE_EN
        trace_idx = 3'd0; #1;
        check("trace_newest", {32'd0, trace_pc}, {32'd0, 32'h8000_0024});
        trace_idx = 3'd7; #1;
        check("trace_oldest", {32'd0, trace_pc}, {32'd0, 32'h8000_0008});
`endif
        tick(1'b1, 32'h8000_0028, EBREAK, 32'd0, "ebreak0");
        tick(1'b1, 32'h8000_002C, ADDI, 32'd0, "drain1");
        tick(1'b0, 32'd0, ADDI, 32'd0, "drain2");
        check("pre_halt", {63'd0, halted}, 64'd0);
        tick(1'b0, 32'd0, ADDI, 32'd0, "halt_edge");
        check("good_halted", {63'd0, halted}, 64'd1);
        check("good_inst",   inst_cnt, 64'd11);
        check("good_cause",  {62'd0, halt_cause}, 64'd1);
        check("good_trap",   {63'd0, good_trap}, 64'd1);
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h9000_0000, EBREAK, 32'd0, "absorb");

        // ebreak with a0!=0
        reset_pulse();
        tick(1'b1, 32'h0000_1000, ADDI, 32'd1, "pre_bad");
        tick(1'b1, 32'h0000_1004, EBREAK, 32'd1, "ebreak1");
        for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, ADDI, 32'd0, "bad_drain");
        check("bad_trap", {63'd0, good_trap}, 64'd0);
        check("bad_pc",   {32'd0, halt_pc}, {32'd0, 32'h0000_1004});

        // stall: no commits after reset
        reset_pulse();
        for (int i = 0; i < 12; i++) tick(1'b0, 32'd0, ADDI, 32'd0, "stall");
        check("stall_cyc",   cycle_cnt, 64'd8);
        check("stall_cause", {62'd0, halt_cause}, 64'd3);

        // timeout: commit every cycle
        reset_pulse();
        for (int i = 0; i < 104; i++) tick(1'b1, 32'(i * 4), ADDI, 32'd0, "timeout");
        check("timeout_cyc",   cycle_cnt, 64'd99);
        check("timeout_cause", {62'd0, halt_cause}, 64'd2);

        // ebreak on the timeout edge wins
        reset_pulse();
        for (int i = 0; i < 98; i++) tick(1'b1, 32'(i * 4), ADDI, 32'd0, "pri_run");
        tick(1'b1, 32'h0000_0400, EBREAK, 32'd0, "pri_ebreak");
        check("pri_ebreak_cause", {62'd0, halt_cause}, 64'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, ADDI, 32'd0, "pri_drain");

        // timeout and stall reached on the same edge: timeout wins
        reset_pulse();
        for (int i = 0; i < 91; i++) tick(1'b1, 32'(i * 4), ADDI, 32'd0, "ts_run");
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, ADDI, 32'd0, "ts_idle");
        check("ts_cause", {62'd0, halt_cause}, 64'd2);

        // reset on the first DRAIN cycle, then a normal ebreak
        reset_pulse();
        tick(1'b1, 32'h0000_2000, ADDI, 32'd0, "mid_run");
        tick(1'b1, 32'h0000_2004, EBREAK, 32'd0, "mid_ebreak");
        reset_pulse();
        check("mid_cause_clr", {62'd0, halt_cause}, 64'd0);
        tick(1'b1, 32'h0000_3000, ADDI, 32'd0, "post_run");
        tick(1'b1, 32'h0000_3004, EBREAK, 32'd0, "post_ebreak");
        for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, ADDI, 32'd0, "post_drain");
        check("post_halted", {63'd0, halted}, 64'd1);

        // randomized episodes across commit densities
        run_random(70, 3, 110);
        run_random(90, 2, 110);
        run_random(30, 5, 110);
        run_random(100, 0, 110);
        run_random(50, 10, 60);
        run_random(85, 1, 110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
